// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the execute-stage multiply/divide sequencing controllers.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } mul_state_e;

    // funct3[1:0] of the RV32M multiply group
    typedef enum logic [1:0] {
        MOP_MUL    = 2'b00,
        MOP_MULH   = 2'b01,
        MOP_MULHSU = 2'b10,
        MOP_MULHU  = 2'b11
    } mul_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mul_decode.sv
// Combinational RV32M multiply detector; register fields are irrelevant to the decision.
module mul_decode
    import mul_ctrl_pkg::*;
(
    input  logic [31:0] InstrE,
    output logic        is_mul,
    output mul_op_e     mul_op
);

    logic unused_instr_s;

    assign unused_instr_s = ^{InstrE[24:15], InstrE[11:7]};

    // funct3[2] set selects DIV/REM, which belong to the divider controller
    assign is_mul = (InstrE[6:0] == OPC_OP) && (InstrE[31:25] == F7_MULDIV) && !InstrE[14];
    assign mul_op = mul_op_e'(InstrE[13:12]);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Launches the iterative multiplier for multiplies in E, stalls the front of the pipe
// until the result lands, and drains operations orphaned by a flush.
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrE,
    input  logic        validE,
    input  logic        flushE,
    input  logic        done_mul,
    output logic        start_mul,
    output logic        mul_switch,
    output logic [1:0]  mul_op,
    output logic        stall_mul,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    mul_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    mul_op_e          mul_op_r;
    mul_op_e          dec_op_s;
    logic             busy_r;
    logic             timeout_err_r;
    logic             is_mul_s;
    logic             mul_det_s;
    logic             timeout_s;
    logic             start_s;
    logic             switch_s;
    logic             stall_s;

    mul_decode u_decode (
        .InstrE (InstrE),
        .is_mul (is_mul_s),
        .mul_op (dec_op_s)
    );

    assign mul_det_s  = validE && is_mul_s && !flushE;
    assign cnt_next_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    // The launch cycle counts toward the wait, so the limit is hit one count early
    assign timeout_s  = (cnt_next_s == TO_LAST);

    // Sequencing FSM with counter, registered op, busy and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            cnt_r         <= CNT_ZERO;
            mul_op_r      <= MOP_MUL;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mul_det_s) begin
                        state_r  <= S_RUN;
                        cnt_r    <= CNT_ZERO;
                        mul_op_r <= dec_op_s;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (done_mul && flushE) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (done_mul) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                    end else if (flushE) begin
                        state_r <= S_DRAIN;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                    end else if (timeout_s) begin
                        state_r       <= S_DONE;
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_next_s;
                        busy_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_DRAIN: begin
                    if (done_mul) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (timeout_s) begin
                        state_r       <= S_IDLE;
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_next_s;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Launch, steering and stall decode; IDLE terms follow E directly so forwarded operands are caught
    always_comb begin
        start_s  = 1'b0;
        switch_s = 1'b0;
        stall_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mul_det_s) begin
                    start_s  = 1'b1;
                    switch_s = 1'b1;
                    stall_s  = 1'b1;
                end else begin
                    start_s  = 1'b0;
                    switch_s = 1'b0;
                    stall_s  = 1'b0;
                end
            end
            S_RUN: begin
                switch_s = !flushE;
                stall_s  = !flushE;
            end
            S_DONE: begin
                switch_s = 1'b1;
            end
            S_DRAIN: begin
                stall_s = mul_det_s;
            end
            default: begin
                start_s  = 1'b0;
                switch_s = 1'b0;
                stall_s  = 1'b0;
            end
        endcase
    end

    // Reset must silence the E-driven terms too, not only the registered ones
    assign start_mul   = start_s && !rst;
    assign mul_switch  = switch_s && !rst;
    assign stall_mul   = stall_s && !rst;
    assign mul_op      = mul_op_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule
